dm_sram_slave: RTL and testbench



---
 rtl/dm_sram_pkg.sv | 17 +
 rtl/dm_sram_slave.sv | 201 ++++++++++++++++++++
 tb/tb_dm_sram_slave.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_sram_pkg.sv
// rtl/dm_sram_pkg.sv - shared constants for the data-memory SRAM AXI slave
package dm_sram_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_DATA = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/dm_sram_slave.sv
// rtl/dm_sram_slave.sv - single-transaction AXI4 slave driving a 32-bit single-port SRAM
module dm_sram_slave
  import dm_sram_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 14
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              SRAM_CEB,
  output logic [3:0]        SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [31:0]       SRAM_DI,
  input  logic [31:0]       SRAM_DO
);

  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rd_first_q, rd_first_d;

  logic              last_beat;
  logic [ADDR_W-1:0] addr_step;
  logic              aw_hs, ar_hs, w_hs, r_hs;
  logic              unused_inputs;

  assign unused_inputs = ^{AWSIZE, ARSIZE, AWADDR[31:ADDR_W+2], AWADDR[1:0],
                           ARADDR[31:ADDR_W+2], ARADDR[1:0]};

  assign last_beat = (beat_q == len_q);
  // WRAP bursts are stepped like INCR; only FIXED holds the address.
  assign addr_step = (burst_q == BURST_FIXED) ? addr_q
                                              : addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign aw_hs = AWVALID && AWREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign w_hs  = WVALID && WREADY;
  assign r_hs  = RVALID && RREADY;

  always_comb begin
    AWREADY  = 1'b0;
    ARREADY  = 1'b0;
    WREADY   = 1'b0;
    BVALID   = 1'b0;
    BID      = '0;
    BRESP    = RESP_OKAY;
    RVALID   = 1'b0;
    RID      = '0;
    RDATA    = '0;
    RRESP    = RESP_OKAY;
    RLAST    = 1'b0;
    SRAM_CEB = 1'b1;
    SRAM_WEB = 4'hF;
    SRAM_A   = '0;
    SRAM_DI  = '0;
    if (!ARESET) begin
      SRAM_A = addr_q;
      case (state_q)
        IDLE: begin
          AWREADY = 1'b1;
          ARREADY = !AWVALID;
        end
        WR_DATA: begin
          WREADY = 1'b1;
          if (WVALID) begin
            SRAM_CEB = 1'b0;
            SRAM_WEB = WSTRB;
            SRAM_DI  = WDATA;
          end
        end
        WR_RESP: begin
          BVALID = 1'b1;
          BID    = id_q;
          BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
        end
        RD_REQ: SRAM_CEB = 1'b0;
        RD_RESP: begin
          RVALID = 1'b1;
          RID    = id_q;
          RLAST  = last_beat;
          // SRAM_DO is only valid in the cycle right after the read strobe.
          RDATA  = rd_first_q ? SRAM_DO : rdata_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rd_first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = AWID;
          addr_d  = AWADDR[ADDR_W+1:2];
          len_d   = AWLEN;
          burst_d = AWBURST;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = WR_DATA;
        end else if (ar_hs) begin
          id_d    = ARID;
          addr_d  = ARADDR[ADDR_W+1:2];
          len_d   = ARLEN;
          burst_d = ARBURST;
          beat_d  = '0;
          state_d = RD_REQ;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          if (WLAST != last_beat) err_d = 1'b1;
          addr_d = addr_step;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: if (BREADY) state_d = IDLE;
      RD_REQ: begin
        state_d    = RD_RESP;
        rd_first_d = 1'b1;
      end
      RD_RESP: begin
        if (rd_first_q) rdata_d = SRAM_DO;
        if (r_hs) begin
          addr_d  = addr_step;
          beat_d  = beat_q + 8'd1;
          state_d = last_beat ? IDLE : RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= BURST_FIXED;
      beat_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rd_first_q <= rd_first_d;
    end
  end

endmodule

// File: tb/tb_dm_sram_slave.sv
// tb/tb_dm_sram_slave.sv - directed bench for dm_sram_slave with a behavioural SRAM
module tb_dm_sram_slave;
  import dm_sram_pkg::*;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 14;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [ID_W-1:0]   AWID, ARID, BID, RID;
  logic [31:0]       AWADDR, ARADDR, WDATA, RDATA, SRAM_DI, SRAM_DO;
  logic [7:0]        AWLEN, ARLEN;
  logic [2:0]        AWSIZE, ARSIZE;
  logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
  logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RLAST, RVALID, RREADY, SRAM_CEB;
  logic [3:0]        WSTRB, SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;

  dm_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI),
    .SRAM_DO(SRAM_DO)
  );

  always #5 ACLK = ~ACLK;

  // Byte-masked SRAM; output scrambles when not strobed so stale-data reuse is visible.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge ACLK) begin
    if (!SRAM_CEB) begin
      for (int i = 0; i < 4; i++)
        if (!SRAM_WEB[i]) mem[SRAM_A][8*i +: 8] <= SRAM_DI[8*i +: 8];
      SRAM_DO <= mem[SRAM_A];
    end else begin
      SRAM_DO <= ~SRAM_DO;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic [31:0] wdata_a [16];
  logic [3:0]  wstrb_a [16];
  logic [31:0] rexp_a  [16];

  task automatic wait_addr_ready(input bit is_ar);
    int n = 0;
    @(negedge ACLK);
    while (!(is_ar ? ARREADY : AWREADY) && n < 20) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      n++;
    end
    chk(is_ar ? "arready" : "awready", 32'(is_ar ? ARREADY : AWREADY), 32'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int bad_beat, output logic [1:0] bresp);
    logic [ADDR_W-1:0] ea;
    ea = addr[ADDR_W+1:2];
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
    wait_addr_ready(1'b0);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WVALID = 1'b1; WDATA = wdata_a[b]; WSTRB = wstrb_a[b];
      WLAST = (b == int'(len)) ^ (b == bad_beat);
      @(negedge ACLK);
      chk("w_ready", 32'(WREADY), 32'd1);
      chk("w_ceb", 32'(SRAM_CEB), 32'd0);
      chk("w_addr", 32'(SRAM_A), 32'(ea));
      chk("w_web", 32'(SRAM_WEB), 32'(wstrb_a[b]));
      chk("w_di", SRAM_DI, wdata_a[b]);
      @(posedge ACLK); #1;
      if (burst != BURST_FIXED) ea = ea + 14'd1;
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    chk("bvalid", 32'(BVALID), 32'd1);
    chk("bid", 32'(BID), 32'(id));
    chk("rvalid_during_b", 32'(RVALID), 32'd0);
    bresp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic rd_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall);
    logic [ADDR_W-1:0] ea;
    ea = addr[ADDR_W+1:2];
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
    wait_addr_ready(1'b1);
    ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge ACLK);
      chk("rq_ceb", 32'(SRAM_CEB), 32'd0);
      chk("rq_web", 32'(SRAM_WEB), 32'hF);
      chk("rq_addr", 32'(SRAM_A), 32'(ea));
      chk("rq_rvalid", 32'(RVALID), 32'd0);
      @(posedge ACLK); #1;
      if (b == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge ACLK);
          chk("stall_rvalid", 32'(RVALID), 32'd1);
          chk("stall_rdata", RDATA, rexp_a[0]);
          chk("stall_ceb", 32'(SRAM_CEB), 32'd1);
          @(posedge ACLK); #1;
        end
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      chk("r_valid", 32'(RVALID), 32'd1);
      chk("r_data", RDATA, rexp_a[b]);
      chk("r_last", 32'(RLAST), 32'(b == int'(len)));
      chk("r_id", 32'(RID), 32'(id));
      chk("r_resp", 32'(RRESP), 32'd0);
      chk("bvalid_during_r", 32'(BVALID), 32'd0);
      @(posedge ACLK); #1;
      RREADY = 1'b0;
      if (burst != BURST_FIXED) ea = ea + 14'd1;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] br;
    vecs[0] = '{1'b1, 32'h10, 32'h0000_1200, 4'b1101, 32'h0};
    vecs[1] = '{1'b0, 32'h10, 32'h0,         4'b0000, 32'hDEAD_12EF};
    vecs[2] = '{1'b1, 32'h40, 32'h1234_5678, 4'b0000, 32'h0};
    vecs[3] = '{1'b1, 32'h40, 32'hAAAA_AAAA, 4'b1110, 32'h0};
    vecs[4] = '{1'b1, 32'h40, 32'h5555_5555, 4'b0111, 32'h0};
    vecs[5] = '{1'b0, 32'h40, 32'h0,         4'b0000, 32'h5534_56AA};
    vecs[6] = '{1'b1, 32'h44, 32'hCAFE_F00D, 4'b0000, 32'h0};
    vecs[7] = '{1'b1, 32'h44, 32'h1111_1111, 4'b1111, 32'h0};
    vecs[8] = '{1'b0, 32'h44, 32'h0,         4'b0000, 32'hCAFE_F00D};

    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b1;
    RREADY = 1'b0;
    ARESET = 1'b1;

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_ceb", 32'(SRAM_CEB), 32'd1);
    chk("rst_web", 32'(SRAM_WEB), 32'hF);
    chk("rst_addr", 32'(SRAM_A), 32'd0);
    chk("rst_di", SRAM_DI, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK);
    chk("idle_awready", 32'(AWREADY), 32'd1);
    chk("idle_arready", 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;

    wdata_a[0] = 32'hDEAD_BEEF; wstrb_a[0] = 4'b0000;
    wr_burst(8'h5A, 32'h0000_0010, 8'd0, BURST_INCR, -1, br);
    chk("single_bresp", 32'(br), 32'(RESP_OKAY));

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) begin
        wdata_a[0] = vecs[i].data; wstrb_a[0] = vecs[i].strb;
        wr_burst(8'(8'h40 + i), vecs[i].addr, 8'd0, BURST_INCR, -1, br);
        chk("vec_bresp", 32'(br), 32'(RESP_OKAY));
      end else begin
        rexp_a[0] = vecs[i].exp;
        rd_burst(8'(8'h40 + i), vecs[i].addr, 8'd0, BURST_INCR, 0);
      end
    end

    for (int i = 0; i < 4; i++) begin
      wdata_a[i] = 32'h1000_0000 + i; wstrb_a[i] = 4'b0000; rexp_a[i] = 32'h1000_0000 + i;
    end
    wr_burst(8'h01, 32'h0000_0020, 8'd3, BURST_INCR, -1, br);
    chk("incr_wr_bresp", 32'(br), 32'(RESP_OKAY));
    rd_burst(8'h02, 32'h0000_0020, 8'd3, BURST_INCR, 0);

    rexp_a[0] = 32'h1000_0000;
    rd_burst(8'h03, 32'h0000_0020, 8'd0, BURST_INCR, 5);

    rexp_a[0] = 32'h1000_0000; rexp_a[1] = 32'h1000_0000;
    rd_burst(8'h04, 32'h0000_0020, 8'd1, BURST_FIXED, 0);

    wdata_a[0] = 32'hA5A5_A5A5; wdata_a[1] = 32'h5A5A_5A5A;
    wstrb_a[0] = 4'b0000;       wstrb_a[1] = 4'b0000;
    wr_burst(8'h05, 32'h0000_FFFC, 8'd1, BURST_INCR, -1, br);
    rexp_a[0] = 32'hA5A5_A5A5; rexp_a[1] = 32'h5A5A_5A5A;
    rd_burst(8'h06, 32'h0000_FFFC, 8'd1, BURST_WRAP, 0);

    // Write wins over a simultaneous read; early WLAST flags SLVERR.
    AWID = 8'h11; AWADDR = 32'h80; AWLEN = 8'd1; AWBURST = BURST_INCR; AWVALID = 1'b1;
    ARID = 8'h22; ARADDR = 32'h20; ARLEN = 8'd0; ARBURST = BURST_INCR; ARVALID = 1'b1;
    @(negedge ACLK);
    chk("both_awready", 32'(AWREADY), 32'd1);
    chk("both_arready", 32'(ARREADY), 32'd0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h0000_0001; WSTRB = 4'b0000; WLAST = 1'b1;
    @(negedge ACLK);
    chk("wr_arready", 32'(ARREADY), 32'd0);
    @(posedge ACLK); #1;
    WDATA = 32'h0000_0002; WLAST = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    chk("err_bvalid", 32'(BVALID), 32'd1);
    chk("err_bresp", 32'(BRESP), 32'(RESP_SLVERR));
    chk("err_bid", 32'(BID), 32'h11);
    chk("err_arready", 32'(ARREADY), 32'd0);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk("after_b_arready", 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("after_b_rvalid", 32'(RVALID), 32'd1);
    chk("after_b_rid", 32'(RID), 32'h22);
    chk("after_b_rdata", RDATA, 32'h1000_0000);
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    chk("err_beat1_mem", mem[33], 32'h0000_0002);

    wdata_a[0] = 32'h6666_6666; wstrb_a[0] = 4'b0000;
    wr_burst(8'h07, 32'h0000_0108, 8'd0, BURST_INCR, -1, br);

    // Reset during beat 2 of an 8-beat write must suppress that beat's SRAM write.
    AWID = 8'h33; AWADDR = 32'h100; AWLEN = 8'd7; AWBURST = BURST_INCR; AWVALID = 1'b1;
    wait_addr_ready(1'b0);
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WVALID = 1'b1; WDATA = 32'h7700_0000 + b; WSTRB = 4'b0000; WLAST = 1'b0;
      @(posedge ACLK); #1;
    end
    WDATA = 32'h7700_0002; ARESET = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_wready", 32'(WREADY), 32'd0);
    chk("mid_rst_ceb", 32'(SRAM_CEB), 32'd1);
    chk("mid_rst_web", 32'(SRAM_WEB), 32'hF);
    chk("mid_rst_addr", 32'(SRAM_A), 32'd0);
    chk("mid_rst_di", SRAM_DI, 32'd0);
    chk("mid_rst_bvalid", 32'(BVALID), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", 32'(AWREADY), 32'd1);
    chk("post_rst_wready", 32'(WREADY), 32'd0);
    chk("post_rst_bvalid", 32'(BVALID), 32'd0);
    chk("post_rst_ceb", 32'(SRAM_CEB), 32'd1);
    chk("beat1_mem", mem[65], 32'h7700_0001);
    chk("beat2_mem", mem[66], 32'h6666_6666);
    @(posedge ACLK); #1;
    rexp_a[0] = 32'h6666_6666;
    rd_burst(8'h08, 32'h0000_0108, 8'd0, BURST_INCR, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
